// File: rtl/game_pkg.sv
// Shared screen geometry, colour constants and renderer state encoding.
// The BAR state exists only when FRAME_RENDERER_HEALTH_BAR_EN is defined.
package game_pkg;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int PIX_COUNT = SCREEN_W * SCREEN_H;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_WHITE = 3'b111;
    localparam logic [2:0] COL_GREEN = 3'b010;
    localparam logic [2:0] COL_RED   = 3'b100;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        USER,
        ENEMY,
`ifdef FRAME_RENDERER_HEALTH_BAR_EN
        BAR,
`endif
        DONE
    } render_state_t;

endpackage

// File: rtl/sprite_rect_scanner.sv
// Walks a SHIP_W x SHIP_H rectangle from a base corner, one offset per enabled
// cycle, flagging pixels that fall off-screen. Counters wrap so it can be reused.
module sprite_rect_scanner
    import game_pkg::*;
#(
    parameter int SHIP_W = 8,
    parameter int SHIP_H = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       en,
    input  logic [7:0] base_x,
    input  logic [6:0] base_y,
    output logic [7:0] pix_x,
    output logic [6:0] pix_y,
    output logic       plot,
    output logic       last
);

    localparam int DXW = (SHIP_W > 1) ? $clog2(SHIP_W) : 1;
    localparam int DYW = (SHIP_H > 1) ? $clog2(SHIP_H) : 1;

    logic [DXW-1:0] dx_reg;
    logic [DYW-1:0] dy_reg;
    logic [8:0]     sum_x;
    logic [7:0]     sum_y;
    logic           dx_end;
    logic           dy_end;

    assign dx_end = (dx_reg == DXW'(SHIP_W - 1));
    assign dy_end = (dy_reg == DYW'(SHIP_H - 1));

    // One bit wider than the coordinate so a sprite hanging off the edge cannot wrap
    assign sum_x = {1'b0, base_x} + 9'(dx_reg);
    assign sum_y = {1'b0, base_y} + 8'(dy_reg);

    assign pix_x = sum_x[7:0];
    assign pix_y = sum_y[6:0];
    assign plot  = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
    assign last  = dx_end && dy_end;

    always_ff @(posedge clk) begin
        if (reset || start) begin
            dx_reg <= '0;
            dy_reg <= '0;
        end else if (en) begin
            if (dx_end) begin
                dx_reg <= '0;
                dy_reg <= dy_end ? '0 : dy_reg + 1'b1;
            end else begin
                dx_reg <= dx_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_renderer.sv
// Per-frame pixel stream generator: bullet grid scan, user sprite, enemy sprite,
// and an optional health bar when FRAME_RENDERER_HEALTH_BAR_EN is defined.
module frame_renderer
    import game_pkg::*;
#(
    parameter int SHIP_W = 8,
    parameter int SHIP_H = 8,
    parameter int BAR_Y  = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          draw_start,
    input  logic [SCREEN_W*SCREEN_H-1:0]  grid,
    input  logic [7:0]                    user_x,
    input  logic [6:0]                    user_y,
    input  logic [7:0]                    enemy_x,
    input  logic [6:0]                    enemy_y,
    input  logic [3:0]                    ship_health,
    output logic [7:0]                    vga_x,
    output logic [6:0]                    vga_y,
    output logic [2:0]                    vga_colour,
    output logic                          vga_plot,
    output logic                          busy,
    output logic                          draw_done
);

    render_state_t state_reg;
    logic [7:0]    scan_x_reg;
    logic [6:0]    scan_y_reg;
    logic [14:0]   scan_idx_reg;
    logic [7:0]    user_x_reg;
    logic [6:0]    user_y_reg;
    logic [7:0]    enemy_x_reg;
    logic [6:0]    enemy_y_reg;

    logic          start_accept;
    logic          sprite_en;
    logic [7:0]    sprite_base_x;
    logic [6:0]    sprite_base_y;
    logic [7:0]    sprite_x;
    logic [6:0]    sprite_y;
    logic          sprite_plot;
    logic          sprite_last;

`ifdef FRAME_RENDERER_HEALTH_BAR_EN
    logic [3:0]    health_reg;
    logic [3:0]    bar_cnt_reg;
`else
    logic          unused_health;
    assign unused_health = ^ship_health;
`endif

    assign start_accept  = (state_reg == IDLE) && draw_start;
    assign sprite_en     = (state_reg == USER) || (state_reg == ENEMY);
    assign sprite_base_x = (state_reg == ENEMY) ? enemy_x_reg : user_x_reg;
    assign sprite_base_y = (state_reg == ENEMY) ? enemy_y_reg : user_y_reg;

    sprite_rect_scanner #(
        .SHIP_W (SHIP_W),
        .SHIP_H (SHIP_H)
    ) u_scanner (
        .clk    (clk),
        .reset  (reset),
        .start  (start_accept),
        .en     (sprite_en),
        .base_x (sprite_base_x),
        .base_y (sprite_base_y),
        .pix_x  (sprite_x),
        .pix_y  (sprite_y),
        .plot   (sprite_plot),
        .last   (sprite_last)
    );

    // Outputs are registered from the current state's counters: one pixel per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            scan_x_reg   <= '0;
            scan_y_reg   <= '0;
            scan_idx_reg <= '0;
            user_x_reg   <= '0;
            user_y_reg   <= '0;
            enemy_x_reg  <= '0;
            enemy_y_reg  <= '0;
            vga_x        <= '0;
            vga_y        <= '0;
            vga_colour   <= '0;
            vga_plot     <= 1'b0;
            busy         <= 1'b0;
            draw_done    <= 1'b0;
`ifdef FRAME_RENDERER_HEALTH_BAR_EN
            health_reg   <= '0;
            bar_cnt_reg  <= '0;
`endif
        end else begin
            vga_plot  <= 1'b0;
            draw_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (draw_start) begin
                        state_reg    <= SCAN;
                        busy         <= 1'b1;
                        scan_x_reg   <= '0;
                        scan_y_reg   <= '0;
                        scan_idx_reg <= '0;
                        user_x_reg   <= user_x;
                        user_y_reg   <= user_y;
                        enemy_x_reg  <= enemy_x;
                        enemy_y_reg  <= enemy_y;
`ifdef FRAME_RENDERER_HEALTH_BAR_EN
                        health_reg   <= ship_health;
                        bar_cnt_reg  <= '0;
`endif
                    end
                end
                SCAN: begin
                    vga_x        <= scan_x_reg;
                    vga_y        <= scan_y_reg;
                    vga_colour   <= grid[scan_idx_reg] ? COL_WHITE : COL_BLACK;
                    vga_plot     <= 1'b1;
                    scan_idx_reg <= scan_idx_reg + 1'b1;
                    if (scan_x_reg == 8'(SCREEN_W - 1)) begin
                        scan_x_reg <= '0;
                        scan_y_reg <= scan_y_reg + 1'b1;
                    end else begin
                        scan_x_reg <= scan_x_reg + 1'b1;
                    end
                    if (scan_idx_reg == 15'(PIX_COUNT - 1)) begin
                        state_reg <= USER;
                    end
                end
                USER: begin
                    vga_x      <= sprite_x;
                    vga_y      <= sprite_y;
                    vga_colour <= COL_GREEN;
                    vga_plot   <= sprite_plot;
                    if (sprite_last) begin
                        state_reg <= ENEMY;
                    end
                end
                ENEMY: begin
                    vga_x      <= sprite_x;
                    vga_y      <= sprite_y;
                    vga_colour <= COL_RED;
                    vga_plot   <= sprite_plot;
                    if (sprite_last) begin
`ifdef FRAME_RENDERER_HEALTH_BAR_EN
                        state_reg <= BAR;
`else
                        state_reg <= DONE;
`endif
                    end
                end
`ifdef FRAME_RENDERER_HEALTH_BAR_EN
                BAR: begin
                    vga_x       <= {4'b0000, bar_cnt_reg};
                    vga_y       <= 7'(BAR_Y);
                    vga_colour  <= (bar_cnt_reg < health_reg) ? COL_RED : COL_BLACK;
                    vga_plot    <= 1'b1;
                    bar_cnt_reg <= bar_cnt_reg + 1'b1;
                    if (bar_cnt_reg == 4'd15) begin
                        state_reg <= DONE;
                    end
                end
`endif
                DONE: begin
                    draw_done <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_renderer.sv
// Directed bench for frame_renderer: grid scan, sprite placement and clipping,
// start-while-busy, mid-frame reset, and the health bar when it is built in.
module tb_frame_renderer;
    import game_pkg::*;

    localparam int SCAN_LEN = SCREEN_W * SCREEN_H;
    localparam int SPR      = 64;
`ifdef FRAME_RENDERER_HEALTH_BAR_EN
    localparam int FRAME_LEN = SCAN_LEN + 2 * SPR + 16 + 1;
`else
    localparam int FRAME_LEN = SCAN_LEN + 2 * SPR + 1;
`endif

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         draw_start;
    logic [SCREEN_W*SCREEN_H-1:0] grid;
    logic [7:0]                   user_x;
    logic [6:0]                   user_y;
    logic [7:0]                   enemy_x;
    logic [6:0]                   enemy_y;
    logic [3:0]                   ship_health;
    logic [7:0]                   vga_x;
    logic [6:0]                   vga_y;
    logic [2:0]                   vga_colour;
    logic                         vga_plot;
    logic                         busy;
    logic                         draw_done;

    frame_renderer dut (
        .clk         (clk),
        .reset       (reset),
        .draw_start  (draw_start),
        .grid        (grid),
        .user_x      (user_x),
        .user_y      (user_y),
        .enemy_x     (enemy_x),
        .enemy_y     (enemy_y),
        .ship_health (ship_health),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .busy        (busy),
        .draw_done   (draw_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int ux, uy, ex, ey, hp;
    int mid_start_at, move_at;
    int scan_plots, scan_white, white_cycle, scan_err;
    int user_plots, user_bad, enemy_plots, enemy_bad;
    int bar_red, bar_black, bar_err;
    int extra_plots, done_count, done_cycle, busy_err;
    logic [63:0] ucov, ecov;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_vga_x"}, int'(vga_x), 0);
        check({tag, "_vga_y"}, int'(vga_y), 0);
        check({tag, "_colour"}, int'(vga_colour), 0);
        check({tag, "_plot"}, int'(vga_plot), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(draw_done), 0);
    endtask

    // Cycle c = c-th falling edge after the rising edge that accepted draw_start
    task automatic run_frame(input int last_cycle);
        int x, y, p, b;
        logic [2:0] bc;
        scan_plots = 0; scan_white = 0; white_cycle = -1; scan_err = 0;
        user_plots = 0; user_bad = 0; enemy_plots = 0; enemy_bad = 0;
        bar_red = 0; bar_black = 0; bar_err = 0;
        extra_plots = 0; done_count = 0; done_cycle = -1; busy_err = 0;
        ucov = '0; ecov = '0;
        @(negedge clk);
        draw_start = 1'b1;
        for (int c = 0; c <= last_cycle; c++) begin
            @(negedge clk);
            draw_start = (c == mid_start_at);
            if (c == move_at) user_x = 8'd40;
            x = int'(vga_x);
            y = int'(vga_y);
            if (int'(busy) != ((c < FRAME_LEN) ? 1 : 0)) busy_err++;
            if (draw_done) begin
                done_count++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (c >= 1 && c <= SCAN_LEN) begin
                p = c - 1;
                if (vga_plot) scan_plots++;
                if (!vga_plot || x != p % SCREEN_W || y != p / SCREEN_W) scan_err++;
                if (vga_colour == 3'b111) begin
                    scan_white++;
                    white_cycle = c;
                end else if (vga_colour != 3'b000) begin
                    scan_err++;
                end
            end else if (c > SCAN_LEN && c <= SCAN_LEN + SPR) begin
                if (vga_plot) begin
                    user_plots++;
                    if (vga_colour != 3'b010 || x < ux || x > ux + 7 || y < uy || y > uy + 7)
                        user_bad++;
                    else
                        ucov[(x - ux) + 8 * (y - uy)] = 1'b1;
                end
            end else if (c > SCAN_LEN + SPR && c <= SCAN_LEN + 2 * SPR) begin
                if (vga_plot) begin
                    enemy_plots++;
                    if (vga_colour != 3'b100 || x < ex || x > ex + 7 || y < ey || y > ey + 7)
                        enemy_bad++;
                    else
                        ecov[(x - ex) + 8 * (y - ey)] = 1'b1;
                end
            end else if (c > SCAN_LEN + 2 * SPR && c < FRAME_LEN) begin
                b = c - (SCAN_LEN + 2 * SPR + 1);
                bc = (b < hp) ? 3'b100 : 3'b000;
                if (!vga_plot || x != b || y != 0 || vga_colour != bc) bar_err++;
                else if (bc == 3'b100) bar_red++;
                else bar_black++;
            end else if (c >= FRAME_LEN) begin
                if (vga_plot) extra_plots++;
            end
        end
        draw_start = 1'b0;
    endtask

    initial begin
        int late_done;
        reset = 1'b1;
        draw_start = 1'b0;
        grid = '0;
        user_x = 8'd10;  user_y = 7'd100;
        enemy_x = 8'd70; enemy_y = 7'd5;
        ship_health = 4'd5;
        hp = 5;
        mid_start_at = -1;
        move_at = -1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Frame A: one bullet, second start mid-SCAN, user_x moved mid-frame
        grid[5 * 160 + 3] = 1'b1;
        ux = 10; uy = 100; ex = 70; ey = 5;
        mid_start_at = 5000;
        move_at = 6000;
        run_frame(FRAME_LEN + 20);
        $display("frame A: scan_plots=%0d white=%0d@%0d user=%0d enemy=%0d done@%0d x%0d",
                 scan_plots, scan_white, white_cycle, user_plots, enemy_plots, done_cycle, done_count);
        check("A_scan_plots", scan_plots, SCAN_LEN);
        check("A_scan_err", scan_err, 0);
        check("A_white_count", scan_white, 1);
        check("A_white_cycle", white_cycle, 5 * 160 + 3 + 1);
        check("A_user_plots", user_plots, 64);
        check("A_user_bad", user_bad, 0);
        check("A_user_cover", $countones(ucov), 64);
        check("A_enemy_plots", enemy_plots, 64);
        check("A_enemy_bad", enemy_bad, 0);
        check("A_enemy_cover", $countones(ecov), 64);
        check("A_done_cycle", done_cycle, FRAME_LEN);
        check("A_done_count", done_count, 1);
        check("A_busy_err", busy_err, 0);
        check("A_extra_plots", extra_plots, 0);
        mid_start_at = -1;
        move_at = -1;
        user_x = 8'd10;

        // Frame B: reset while drawing the user sprite
        grid = '0;
        user_x = 8'd20; user_y = 7'd30;
        ux = 20; uy = 30;
        run_frame(SCAN_LEN + 30);
        check("B_user_partial", user_plots, 30);
        reset = 1'b1;
        @(negedge clk);
        $display("frame B: reset in USER, plot=%0d busy=%0d done=%0d", vga_plot, busy, draw_done);
        check_outputs_zero("B_reset");
        reset = 1'b0;
        late_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (draw_done || busy || vga_plot) late_done++;
        end
        check("B_quiet_after_reset", late_done, 0);

        // Frame C: user sprite clipped at the bottom-right corner
        user_x = 8'd156; user_y = 7'd116;
        ux = 156; uy = 116; ex = 70; ey = 5;
        run_frame(FRAME_LEN + 20);
        $display("frame C: scan_plots=%0d user=%0d enemy=%0d bar=%0d/%0d done@%0d x%0d",
                 scan_plots, user_plots, enemy_plots, bar_red, bar_black, done_cycle, done_count);
        check("C_scan_plots", scan_plots, SCAN_LEN);
        check("C_scan_err", scan_err, 0);
        check("C_white_count", scan_white, 0);
        check("C_user_plots", user_plots, 16);
        check("C_user_bad", user_bad, 0);
        check("C_user_cover", $countones(ucov), 16);
        check("C_enemy_plots", enemy_plots, 64);
        check("C_enemy_bad", enemy_bad, 0);
        check("C_done_cycle", done_cycle, FRAME_LEN);
        check("C_done_count", done_count, 1);
        check("C_busy_err", busy_err, 0);
        check("C_extra_plots", extra_plots, 0);
`ifdef FRAME_RENDERER_HEALTH_BAR_EN
        check("C_bar_red", bar_red, 5);
        check("C_bar_black", bar_black, 11);
        check("C_bar_err", bar_err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frame_renderer.md
Name: frame_renderer

Overview:
- Consumer end of the game-logic outputs: reads the bullet grid, user/enemy positions and ship health, and turns them into a pixel-write stream for the VGA adapter (x, y, colour, plot).
- Started once per frame by the top-level FSM with a start pulse; signals completion with a done pulse.
- Sits between the logic handler and the VGA adapter.

Parameters:
- SCREEN_W, 160, screen width in pixels.
- SCREEN_H, 120, screen height in pixels.
- SHIP_W, 8, sprite width in pixels (both ships).
- SHIP_H, 8, sprite height in pixels (both ships).
- BAR_Y, 0, row used by the optional health bar.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- draw_start  in  1  one-cycle frame-start request from the FSM.
- grid  in  SCREEN_W*SCREEN_H  bullet bitmap; bit index y*SCREEN_W+x, 1 = bullet.
- user_x  in  8  user ship left column.
- user_y  in  7  user ship top row.
- enemy_x  in  8  enemy ship left column.
- enemy_y  in  7  enemy ship top row.
- ship_health  in  4  user health, 0..15.
- vga_x  out  8  pixel column.
- vga_y  out  7  pixel row.
- vga_colour  out  3  RGB colour, 1 bit per channel.
- vga_plot  out  1  write-enable for the current pixel.
- busy  out  1  high from the cycle after an accepted start until done.
- draw_done  out  1  one-cycle pulse after the last pixel of the frame.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-frame aborts immediately with no draw_done.
- States:
  - IDLE: on draw_start go to SCAN; counters cleared; busy=1 next cycle.
  - SCAN: raster order, x fastest (0..SCREEN_W-1), then y.
  - USER: SHIP_W*SHIP_H cycles, user sprite.
  - ENEMY: SHIP_W*SHIP_H cycles, enemy sprite.
  - BAR: 16 cycles, only when the optional feature is enabled.
  - DONE: one cycle.
- draw_start is ignored unless the state is IDLE. Requests while busy are dropped, not queued.
- Pixel outputs are registered: counter value at cycle k appears on vga_* at cycle k+1. Exactly one pixel per cycle, no stalls.
- SCAN:
  - vga_plot=1 for every pixel.
  - Colour is 3'b111 if grid[y*SCREEN_W+x]=1, else 3'b000.
  - Takes SCREEN_W*SCREEN_H = 19200 cycles.
- USER/ENEMY:
  - Offset counters dx (0..SHIP_W-1, fastest) and dy.
  - Pixel is (base_x+dx, base_y+dy); sums computed 1 bit wider than the coordinate.
  - Clipping: if sum_x >= SCREEN_W or sum_y >= SCREEN_H, vga_plot=0 for that cycle, but the cycle is still consumed and the state length is fixed.
  - User colour 3'b010; enemy colour 3'b100.
- Position sampling: user_x/user_y/enemy_x/enemy_y/ship_health are captured into internal registers when draw_start is accepted. Changes mid-frame have no effect.
- grid is read live during SCAN.
- Draw order: enemy drawn after user, so enemy wins where the sprites overlap.
- DONE: draw_done=1 and busy=0 in the same cycle, vga_plot=0, then return to IDLE. A new draw_start is accepted in the IDLE cycle that follows.
- Frame length from start acceptance to draw_done: 19200 + 2*SHIP_W*SHIP_H + 1 cycles = 19329 with defaults (BAR disabled).

Optional Feature:
- Macro: FRAME_RENDERER_HEALTH_BAR_EN.
- Defined: BAR state inserted after ENEMY. Draws x = 0..15 on row BAR_Y.
  - Colour 3'b100 for x < sampled ship_health, else 3'b000; vga_plot=1 for all 16 pixels.
  - Frame length becomes 19345 cycles.
- Undefined: no BAR state, no bar logic; the ship_health port stays but is unused.

Decomposition:
- Shared package game_pkg: SCREEN_W, SCREEN_H, colour constants (COL_BLACK, COL_WHITE, COL_GREEN, COL_RED), renderer state enum.
- One sub-module: sprite_rect_scanner.
  - Inputs: base x/y, start.
  - Outputs: clipped pixel coordinates, plot, last.
  - Instantiated once and reused for USER and ENEMY by muxing the base coordinates.

Test Plan:
- Empty grid, ships at (10,100) and (70,5), start -> 19200 black plots, 64 green plots covering (10..17,100..107), 64 red plots covering (70..77,5..12), draw_done at cycle 19329.
- grid bit 5*160+3 set -> pixel (3,5) plotted 3'b111 at output cycle 5*160+3+1; every other SCAN pixel black.
- user_x=156, user_y=116 -> only 16 plots asserted in USER, for x 156..159 and y 116..119. Frame length unchanged.
- draw_start pulsed again mid-SCAN and user_x changed mid-frame -> no restart, sprite drawn at the position sampled at start, exactly one draw_done.
- reset asserted in USER state -> all outputs 0 next cycle, no draw_done. A later draw_start runs a full frame.
- FRAME_RENDERER_HEALTH_BAR_EN defined, ship_health=5 -> BAR plots (0..4,0) red and (5..15,0) black, draw_done at cycle 19345.
